seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_pkg.sv | 33 +++
 rtl/seg7_hex_decode.sv | 14 +
 rtl/seg7_scan_driver.sv | 159 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment table for the seven-segment scan driver.
// Segment patterns are active-low {a,b,c,d,e,f,g}, with a as the MSB.
package seg7_pkg;

    typedef logic [6:0] seg_pattern_t;

    localparam seg_pattern_t SEG_BLANK = 7'b111_1111;

    function automatic seg_pattern_t hex_to_seg(input logic [3:0] hex);
        seg_pattern_t seg;
        case (hex)
            4'h0:    seg = 7'b000_0001;
            4'h1:    seg = 7'b100_1111;
            4'h2:    seg = 7'b001_0010;
            4'h3:    seg = 7'b000_0110;
            4'h4:    seg = 7'b100_1100;
            4'h5:    seg = 7'b010_0100;
            4'h6:    seg = 7'b010_0000;
            4'h7:    seg = 7'b000_1111;
            4'h8:    seg = 7'b000_0000;
            4'h9:    seg = 7'b000_0100;
            4'hA:    seg = 7'b000_1000;
            4'hB:    seg = 7'b110_0000;
            4'hC:    seg = 7'b011_0001;
            4'hD:    seg = 7'b100_0010;
            4'hE:    seg = 7'b011_0000;
            4'hF:    seg = 7'b011_1000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to active-low seven-segment pattern decoder.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Table lookup from the shared package
    always_comb begin
        seg = hex_to_seg(hex);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scan driver with dead time and registered outputs.
// Optional PWM dimming is enabled by defining SEG7_DIMMING_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 100000,
    parameter int BRIGHT_W   = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   digit_en_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [BRIGHT_W-1:0]     brightness_i,
    output logic [NUM_DIGITS-1:0]   anode_o,
    output logic [6:0]              segments_o,
    output logic                    dp_o,
    output logic                    frame_o
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]      presc_r;
    logic [IDX_W-1:0]      idx_r;
    logic                  tick_s;
    logic [IDX_W-1:0]      cap_idx_r;
    logic [3:0]            cap_digit_r;
    logic                  cap_en_r;
    logic                  cap_dp_r;
    logic [IDX_W-1:0]      sel_idx_s;
    logic [3:0]            sel_digit_s;
    logic                  sel_en_s;
    logic                  sel_dp_s;
    logic [6:0]            dec_seg_s;
    logic                  gate_s;
    logic [NUM_DIGITS-1:0] anode_nxt_s;
    logic [6:0]            seg_nxt_s;
    logic                  dp_nxt_s;
    logic                  frame_nxt_s;
    logic [NUM_DIGITS-1:0] anode_r;
    logic [6:0]            seg_r;
    logic                  dp_r;
    logic                  frame_r;

    assign tick_s = (presc_r == PRE_LAST);

    // Slot prescaler and index of the digit captured at the next tick
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_r <= '0;
            idx_r   <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
            idx_r   <= (idx_r == IDX_LAST) ? '0 : idx_r + IDX_W'(1);
        end else begin
            presc_r <= presc_r + PRE_W'(1);
        end
    end

    // Per-slot snapshot so that input changes wait for the digit's next slot
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cap_idx_r   <= '0;
            cap_digit_r <= 4'h0;
            cap_en_r    <= 1'b0;
            cap_dp_r    <= 1'b0;
        end else if (tick_s) begin
            cap_idx_r   <= idx_r;
            cap_digit_r <= digits_i[int'(idx_r)*4 +: 4];
            cap_en_r    <= digit_en_i[idx_r];
            cap_dp_r    <= dp_i[idx_r];
        end
    end

    // On a tick the outputs must already reflect the slot being captured
    always_comb begin
        if (tick_s) begin
            sel_idx_s   = idx_r;
            sel_digit_s = digits_i[int'(idx_r)*4 +: 4];
            sel_en_s    = digit_en_i[idx_r];
            sel_dp_s    = dp_i[idx_r];
        end else begin
            sel_idx_s   = cap_idx_r;
            sel_digit_s = cap_digit_r;
            sel_en_s    = cap_en_r;
            sel_dp_s    = cap_dp_r;
        end
    end

    seg7_hex_decode u_hex_decode (
        .hex (sel_digit_s),
        .seg (dec_seg_s)
    );

`ifdef SEG7_DIMMING_EN
    logic [BRIGHT_W-1:0] pwm_cnt_r;
    logic [BRIGHT_W-1:0] pwm_nxt_s;

    assign pwm_nxt_s = pwm_cnt_r + BRIGHT_W'(1);
    // Gate uses the count that will be live while the registered anode is shown
    assign gate_s    = (pwm_nxt_s <= brightness_i);

    // Free-running PWM counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pwm_cnt_r <= '0;
        end else begin
            pwm_cnt_r <= pwm_nxt_s;
        end
    end
`else
    logic unused_bright_s;

    assign unused_bright_s = ^brightness_i;
    assign gate_s          = 1'b1;
`endif

    // Next output values: dead time on the tick, blanking, dimming gate
    always_comb begin
        anode_nxt_s = '1;
        if (!tick_s && sel_en_s && gate_s) begin
            anode_nxt_s = ~(NUM_DIGITS'(1) << sel_idx_s);
        end else begin
            anode_nxt_s = '1;
        end
        if (sel_en_s) begin
            seg_nxt_s = dec_seg_s;
        end else begin
            seg_nxt_s = SEG_BLANK;
        end
        dp_nxt_s    = ~(sel_en_s & sel_dp_s);
        frame_nxt_s = tick_s && (idx_r == '0);
    end

    // Output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            anode_r <= '1;
            seg_r   <= SEG_BLANK;
            dp_r    <= 1'b1;
            frame_r <= 1'b0;
        end else begin
            anode_r <= anode_nxt_s;
            seg_r   <= seg_nxt_s;
            dp_r    <= dp_nxt_s;
            frame_r <= frame_nxt_s;
        end
    end

    assign anode_o    = anode_r;
    assign segments_o = seg_r;
    assign dp_o       = dp_r;
    assign frame_o    = frame_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver (three parameterisations).
module tb_seg7_scan_driver;

    logic clk_i = 1'b0;
    logic rst_ni;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk_i = ~clk_i;

    logic [15:0] dig4;
    logic [3:0]  en4, dp4, br4, an4;
    logic [6:0]  seg4;
    logic        dpo4, fr4;

    logic [11:0] dig3;
    logic [2:0]  en3, dp3, an3;
    logic [3:0]  br3;
    logic [6:0]  seg3;
    logic        dpo3, fr3;

    logic [3:0]  dig1;
    logic [0:0]  en1, dp1, an1;
    logic [1:0]  br1;
    logic [6:0]  seg1;
    logic        dpo1, fr1;

    seg7_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .BRIGHT_W(4)) u_dut4 (
        .clk_i(clk_i), .rst_ni(rst_ni), .digits_i(dig4), .digit_en_i(en4), .dp_i(dp4),
        .brightness_i(br4), .anode_o(an4), .segments_o(seg4), .dp_o(dpo4), .frame_o(fr4)
    );

    seg7_scan_driver #(.NUM_DIGITS(3), .CLK_DIV(4), .BRIGHT_W(4)) u_dut3 (
        .clk_i(clk_i), .rst_ni(rst_ni), .digits_i(dig3), .digit_en_i(en3), .dp_i(dp3),
        .brightness_i(br3), .anode_o(an3), .segments_o(seg3), .dp_o(dpo3), .frame_o(fr3)
    );

    seg7_scan_driver #(.NUM_DIGITS(1), .CLK_DIV(8), .BRIGHT_W(2)) u_dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .digits_i(dig1), .digit_en_i(en1), .dp_i(dp1),
        .brightness_i(br1), .anode_o(an1), .segments_o(seg1), .dp_o(dpo1), .frame_o(fr1)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // One 4-cycle slot of u_dut4: dead cycle, then three active cycles
    task automatic slot4(input string tag, input logic [3:0] an, input logic [6:0] seg,
                         input logic dp, input logic fr);
        edges(1);
        chk({tag, ".dead_an"}, 16'(an4), 16'h000F);
        chk({tag, ".dead_seg"}, 16'(seg4), 16'(seg));
        chk({tag, ".dead_dp"}, 16'(dpo4), 16'(dp));
        chk({tag, ".dead_frame"}, 16'(fr4), 16'(fr));
        for (int i = 0; i < 3; i++) begin
            edges(1);
            chk({tag, ".an"}, 16'(an4), 16'(an));
            chk({tag, ".seg"}, 16'(seg4), 16'(seg));
            chk({tag, ".frame"}, 16'(fr4), 16'h0000);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        int nf;
        int nl;

        rst_ni = 1'b0;
        dig4 = 16'h4321; en4 = 4'b1111; dp4 = 4'b0100; br4 = 4'h0;
        dig3 = 12'h9A5;  en3 = 3'b111;  dp3 = 3'b000;  br3 = 4'h0;
        dig1 = 4'hF;     en1 = 1'b1;    dp1 = 1'b0;    br1 = 2'b00;

        // reset state
        edges(2);
        chk("rst.an4", 16'(an4), 16'h000F);
        chk("rst.seg4", 16'(seg4), 16'h007F);
        chk("rst.dp4", 16'(dpo4), 16'h0001);
        chk("rst.fr4", 16'(fr4), 16'h0000);
        chk("rst.an3", 16'(an3), 16'h0007);
        chk("rst.dp3", 16'(dpo3), 16'h0001);
        chk("rst.dp1", 16'(dpo1), 16'h0001);

        // scan 1: digits 4321, all enabled, dp on digit 2
        @(negedge clk_i); rst_ni = 1'b1;
        edges(3);
        chk("pre.an", 16'(an4), 16'h000F);
        chk("pre.seg", 16'(seg4), 16'h007F);
        chk("pre.frame", 16'(fr4), 16'h0000);
        slot4("s0", 4'b1110, 7'b100_1111, 1'b1, 1'b1);
        slot4("s1", 4'b1101, 7'b001_0010, 1'b1, 1'b0);
        slot4("s2", 4'b1011, 7'b000_0110, 1'b0, 1'b0);
        slot4("s3", 4'b0111, 7'b100_1100, 1'b1, 1'b0);

        // scan 2: digit 0 changes mid-slot, digit 2 blanked
        edges(1);
        chk("chg.dead_an", 16'(an4), 16'h000F);
        chk("chg.dead_frame", 16'(fr4), 16'h0001);
        edges(1);
        chk("chg.c2_an", 16'(an4), 16'h000E);
        dig4 = 16'h4328;
        en4  = 4'b1011;
        edges(1);
        chk("chg.c3_seg", 16'(seg4), 16'h004F);
        edges(1);
        chk("chg.c4_seg", 16'(seg4), 16'h004F);
        chk("chg.c4_an", 16'(an4), 16'h000E);
        slot4("s1b", 4'b1101, 7'b001_0010, 1'b1, 1'b0);
        slot4("blank2", 4'b1111, 7'b111_1111, 1'b1, 1'b0);
        en4 = 4'b1111;
        slot4("s3b", 4'b0111, 7'b100_1100, 1'b1, 1'b0);

        // scan 3: new digit 0 value now visible
        slot4("s0c", 4'b1110, 7'b000_0000, 1'b1, 1'b1);
        slot4("s1c", 4'b1101, 7'b001_0010, 1'b1, 1'b0);

        // reset in the middle of slot 2
        edges(1);
        chk("mid.dead_seg", 16'(seg4), 16'h0006);
        chk("mid.dead_dp", 16'(dpo4), 16'h0000);
        edges(1);
        chk("mid.an", 16'(an4), 16'h000B);
        #2 rst_ni = 1'b0;
        #1;
        chk("mid.rst_an", 16'(an4), 16'h000F);
        chk("mid.rst_seg", 16'(seg4), 16'h007F);
        chk("mid.rst_dp", 16'(dpo4), 16'h0001);
        chk("mid.rst_frame", 16'(fr4), 16'h0000);
        edges(2);
        chk("mid.hold_an", 16'(an4), 16'h000F);
        @(negedge clk_i); rst_ni = 1'b1;
        edges(3);
        chk("post.pre_an", 16'(an4), 16'h000F);
        chk("post.pre_seg", 16'(seg4), 16'h007F);
        slot4("post0", 4'b1110, 7'b000_0000, 1'b1, 1'b1);

        // three digits: index 0,1,2,0 and frame every 12 cycles
        rst_ni = 1'b0;
        edges(2);
        @(negedge clk_i); rst_ni = 1'b1;
        edges(4);
        chk("n3.f0", 16'(fr3), 16'h0001);
        chk("n3.dead_an", 16'(an3), 16'h0007);
        chk("n3.seg0", 16'(seg3), 16'h0024);
        edges(1);
        chk("n3.an0", 16'(an3), 16'h0006);
        edges(4);
        chk("n3.an1", 16'(an3), 16'h0005);
        chk("n3.seg1", 16'(seg3), 16'h0008);
        edges(4);
        chk("n3.an2", 16'(an3), 16'h0003);
        chk("n3.seg2", 16'(seg3), 16'h0004);
        edges(3);
        chk("n3.wrap_frame", 16'(fr3), 16'h0001);
        chk("n3.wrap_seg", 16'(seg3), 16'h0024);
        gap = 0;
        do begin
            edges(1);
            gap++;
        end while (fr3 !== 1'b1 && gap < 40);
        chk("n3.frame_gap", 16'(gap), 16'd12);
        nf = 0;
        for (int i = 0; i < 24; i++) begin
            edges(1);
            if (fr3 === 1'b1) nf++;
        end
        chk("n3.frame_count", 16'(nf), 16'd2);

        // single digit, CLK_DIV=8, brightness 0
        rst_ni = 1'b0;
        edges(2);
        @(negedge clk_i); rst_ni = 1'b1;
        edges(7);
        chk("n1.pre_an", 16'(an1), 16'h0001);
        chk("n1.pre_frame", 16'(fr1), 16'h0000);
        nl = 0;
        for (int i = 0; i < 8; i++) begin
            edges(1);
            if (i == 0) chk("n1.frame", 16'(fr1), 16'h0001);
            if (an1 === 1'b0) nl++;
        end
`ifdef SEG7_DIMMING_EN
        chk("n1.low_cycles", 16'(nl), 16'd1);
`else
        chk("n1.low_cycles", 16'(nl), 16'd7);
`endif
        chk("n1.seg", 16'(seg1), 16'h0038);
        chk("n1.dp", 16'(dpo1), 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
